div_iter: RTL and testbench
===========================

// Module: div_iter
// PURPOSE
//  Multi-cycle 32-bit signed/unsigned divider. Responder side of the EX-stage divide handshake.
//  EX holds start_i with stable operands and stalls the pipeline until ready_o.
//  It then writes result_o[63:32] (remainder) to HI and result_o[31:0] (quotient) to LO.
//  Algorithm: radix-2 restoring division, one quotient bit per clock.
// PARAMETERS
//  DATA_W  32  operand width; result_o is 2*DATA_W bits; iteration count = DATA_W
// PORTS
//  clk           in   1         clock, rising edge
//  rst           in   1         reset, asynchronous, active-high
//  signed_div_i  in   1         1 = two's-complement divide (DIV), 0 = unsigned (DIVU)
//  opdata1_i     in   DATA_W    dividend
//  opdata2_i     in   DATA_W    divisor
//  start_i       in   1         request; held high by EX until ready_o is seen
//  annul_i       in   1         abort current operation (pipeline flush)
//  result_o      out  2*DATA_W  {remainder, quotient}; valid while ready_o=1, else 0
//  ready_o       out  1         result valid; registered
// BEHAVIOUR
//  Reset: state=IDLE, ready_o=0, result_o=0, counter=0, internal regs=0.
//   Asynchronous: takes effect immediately, including mid-operation; the partial result is discarded.
//  States: IDLE, DIVZERO, ON, END. All outputs are registered.
//  IDLE: on an edge with start_i=1 and annul_i=0:
//   - opdata2_i==0 -> DIVZERO.
//   - else -> ON: latch |a|, |b| (absolute values only if signed_div_i=1),
//     latch sign1, sign2 and signed_div_i; clear the partial remainder; counter=0.
//   Operands are sampled only at this edge; later input changes are ignored.
//  DIVZERO: next edge -> END, result_o=0, ready_o=1. No exception is raised.
//  ON: each edge:
//   - shift {rem, quo} left by 1.
//   - if rem >= b: rem -= b and quotient bit = 1; else quotient bit = 0.
//   - counter++.
//   - On the edge where counter==DATA_W-1 (the DATA_W-th iteration): go to END and set ready_o=1.
//     result_o gets the sign-fixed values:
//     - quotient negated if signed and sign1^sign2.
//     - remainder negated if signed and sign1 (sign follows dividend).
//   annul_i=1 in ON -> IDLE next edge; ready_o stays 0, result_o stays 0.
//  END: hold result_o and ready_o=1 while start_i=1.
//   start_i=0 -> IDLE next edge; ready_o=0 and result_o=0 at that edge.
//   annul_i in END has the same effect as start_i=0.
//  Latency: start sampled at edge E0 -> ready_o high after edge E0+DATA_W (33 edges total for DATA_W=32).
//   Divide-by-zero: ready_o high after edge E0+1.
//  Back-to-back: a new operation may start only from IDLE, i.e. at least one cycle with start_i=0 after ready_o.
//  Arithmetic rules:
//   - Negation is two's complement modulo 2^DATA_W.
//   - 0x80000000 / -1 signed: quotient 0x80000000, remainder 0 (wraps, no trap).
//   - |0x80000000| is treated as unsigned 2^31.
//  Simultaneous start_i and annul_i in IDLE: annul wins; stay in IDLE.
// TESTING
//  1 unsigned 100/7, start held -> ready_o after 32 edges, result_o=64'h00000002_0000000E.
//  2 signed -7/2 (FFFFFFF9/00000002) -> result_o=64'hFFFFFFFF_FFFFFFFD; signed 7/-2 -> 64'h00000001_FFFFFFFD.
//  3 divisor 0, either mode -> ready_o after 2 edges, result_o=0; drop start_i -> ready_o=0 next edge.
//  4 annul_i pulsed at iteration 10 -> IDLE, ready_o never rises; a new 0xFFFFFFFF/0x10 unsigned op
//    then gives 64'h0000000F_0FFFFFFF.
//  5 signed 0x80000000/0xFFFFFFFF -> 64'h00000000_80000000; unsigned same operands -> 64'h80000000_00000000.
//  6 rst asserted mid-ON (between edges) -> ready_o/result_o 0 immediately; start_i held through the
//    release of rst -> full operation restarts, correct result after 32 edges.

Source files
------------

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider (signed/unsigned) answering the EX-stage
// divide handshake: one quotient bit per clock, result held while start_i stays high.
module div_iter #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVZERO,
        S_ON,
        S_END
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]    quo_q, quo_d;
    logic [DATA_W-1:0]    div_q, div_d;
    logic [DATA_W-1:0]    rem_q, rem_d;
    logic                 sign1_q, sign1_d;
    logic                 sign2_q, sign2_d;
    logic                 sdiv_q, sdiv_d;
    logic [2*DATA_W-1:0]  result_q, result_d;
    logic                 ready_q, ready_d;

    logic [DATA_W-1:0]    a_abs, b_abs;
    logic [DATA_W:0]      rem_sh, rem_sub;
    logic                 q_bit;
    logic [DATA_W-1:0]    rem_nx, quo_nx, quo_fix, rem_fix;

    // |x| of the most negative value wraps to itself, read as unsigned 2^(DATA_W-1).
    assign a_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign b_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    // Partial remainder needs one extra bit after the shift; no borrow means rem >= divisor.
    assign rem_sh  = {rem_q, quo_q[DATA_W-1]};
    assign rem_sub = rem_sh - {1'b0, div_q};
    assign q_bit   = ~rem_sub[DATA_W];
    assign rem_nx  = q_bit ? rem_sub[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    assign quo_nx  = {quo_q[DATA_W-2:0], q_bit};

    assign quo_fix = (sdiv_q && (sign1_q ^ sign2_q)) ? -quo_nx : quo_nx;
    assign rem_fix = (sdiv_q && sign1_q) ? -rem_nx : rem_nx;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        div_d    = div_q;
        rem_d    = rem_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        sdiv_d   = sdiv_q;
        result_d = result_q;
        ready_d  = ready_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = S_DIVZERO;
                    end else begin
                        state_d = S_ON;
                        quo_d   = a_abs;
                        div_d   = b_abs;
                        rem_d   = '0;
                        cnt_d   = '0;
                        sign1_d = opdata1_i[DATA_W-1];
                        sign2_d = opdata2_i[DATA_W-1];
                        sdiv_d  = signed_div_i;
                    end
                end
            end
            S_DIVZERO: begin
                if (annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_END;
                    result_d = '0;
                    ready_d  = 1'b1;
                end
            end
            S_ON: begin
                if (annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    quo_d = quo_nx;
                    rem_d = rem_nx;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d  = S_END;
                        result_d = {rem_fix, quo_fix};
                        ready_d  = 1'b1;
                    end
                end
            end
            S_END: begin
                if (!start_i || annul_i) begin
                    state_d  = S_IDLE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            rem_q    <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            sdiv_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            rem_q    <= rem_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            sdiv_q   <= sdiv_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: drivers push {expected result, expected ready cycle},
// a negedge monitor pops on each rising ready_o and compares.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i, opdata2_i;
    logic        start_i, annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    div_iter #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .start_i(start_i), .annul_i(annul_i),
        .result_o(result_o), .ready_o(ready_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic prev_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Division with truncation toward zero; remainder takes the dividend's sign.
    function automatic logic [63:0] model(input bit sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_rdy <= 1'b0;
        end else begin
            if (ready_o && !prev_rdy) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_ready", {63'd0, ready_o}, 64'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("result", result_o, e.res);
                    chk("latency", 64'(cyc), 64'(e.cyc));
                end
            end
            if (!ready_o) chk("result_idle_zero", result_o, 64'd0);
            prev_rdy <= ready_o;
        end
    end

    // Wait for ready_o, hold start_i for 'hold' more cycles, then drop it.
    task automatic finish_op(input int hold);
        bit seen = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (ready_o) begin seen = 1; break; end
        end
        if (!seen) chk("ready_timeout", 64'd0, 64'd1);
        repeat (hold) @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        chk("drop_ready", {63'd0, ready_o}, 64'd0);
    endtask

    task automatic run_op(input bit sg, input logic [31:0] a, input logic [31:0] b,
                          input bit use_exp, input logic [63:0] exp_v, input int hold);
        exp_t e;
        @(negedge clk);
        signed_div_i = sg; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
        e.res = use_exp ? exp_v : model(sg, a, b);
        e.cyc = cyc + ((b == 32'd0) ? 2 : 33);
        sbq.push_back(e);
        finish_op(hold);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(1, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        exp_t e;
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
        signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", {63'd0, ready_o}, 64'd0);
        chk("reset_result", result_o, 64'd0);
        rst = 1'b0;

        run_op(0, 32'd100, 32'd7, 1, 64'h00000002_0000000E, 2);
        run_op(1, 32'hFFFFFFF9, 32'd2, 1, 64'hFFFFFFFF_FFFFFFFD, 0);
        run_op(1, 32'd7, 32'hFFFFFFFE, 1, 64'h00000001_FFFFFFFD, 1);
        run_op(0, 32'd55, 32'd0, 1, 64'd0, 1);
        run_op(1, 32'hDEADBEEF, 32'd0, 1, 64'd0, 0);
        run_op(1, 32'h80000000, 32'hFFFFFFFF, 1, 64'h00000000_80000000, 0);
        run_op(0, 32'h80000000, 32'hFFFFFFFF, 1, 64'h80000000_00000000, 0);

        // Flush at iteration 10: no result may appear.
        @(negedge clk);
        signed_div_i = 0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (11) @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        repeat (40) @(negedge clk);
        chk("annul_no_ready", {63'd0, ready_o}, 64'd0);
        run_op(0, 32'hFFFFFFFF, 32'h10, 1, 64'h0000000F_0FFFFFFF, 0);

        // Start together with annul in IDLE never launches an operation.
        @(negedge clk);
        opdata1_i = 32'd9; opdata2_i = 32'd4; start_i = 1'b1; annul_i = 1'b1;
        repeat (3) @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        repeat (40) @(negedge clk);
        chk("start_annul_idle", {63'd0, ready_o}, 64'd0);

        // Reset mid-operation with start held through release: full restart.
        @(negedge clk);
        signed_div_i = 1; opdata1_i = 32'hFFFFFF9C; opdata2_i = 32'd7; start_i = 1'b1;
        repeat (15) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_on_ready", {63'd0, ready_o}, 64'd0);
        chk("rst_on_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        e.res = 64'hFFFFFFFE_FFFFFFF2;
        e.cyc = cyc + 33;
        sbq.push_back(e);
        finish_op(0);

        // Reset while a result is being held: outputs clear asynchronously.
        @(negedge clk);
        signed_div_i = 0; opdata1_i = 32'd77; opdata2_i = 32'd5; start_i = 1'b1;
        e.res = model(0, 32'd77, 32'd5);
        e.cyc = cyc + 33;
        sbq.push_back(e);
        repeat (35) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_end_ready", {63'd0, ready_o}, 64'd0);
        chk("rst_end_result", result_o, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = pick();
            b = pick();
            run_op(1'($urandom_range(0, 1)), a, b, 0, 64'd0, $urandom_range(0, 3));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
